// File: rtl/wr_data_sequencer.sv
// wr_data_sequencer
// Orders the AXI W channel behind AW acceptance. A circular queue holds
// {slot idx, aw.len} in AW order; its head owns the W channel. W beats are
// counted against the head's length and the head retires on the last beat.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous flush of queue and beat counter
//   aw_push_i          AW handshake this cycle, with aw_idx_i / aw_len_i
//   w_valid_i, w_ready_i, w_last_i   W channel
//   active_valid_o, active_idx_o     current W owner (combinational)
//   beat_cnt_o         beats already accepted for the owner (registered)
//   w_first_o, w_done_o, w_done_idx_o  per-beat pulses (combinational)
//   full_o, empty_o, count_o          queue status (registered)
//   aw_drop_o, err_orphan_o, err_len_o  error pulses (combinational)
module wr_data_sequencer #(
  parameter int unsigned MaxWrTxns  = 8,
  parameter int unsigned LdIdxWidth = 3,
  parameter int unsigned LenWidth   = 8,
  parameter int unsigned CntWidth   = $clog2(MaxWrTxns + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  aw_push_i,
  input  logic [LdIdxWidth-1:0] aw_idx_i,
  input  logic [LenWidth-1:0]   aw_len_i,
  input  logic                  w_valid_i,
  input  logic                  w_ready_i,
  input  logic                  w_last_i,
  output logic                  active_valid_o,
  output logic [LdIdxWidth-1:0] active_idx_o,
  output logic [LenWidth:0]     beat_cnt_o,
  output logic                  w_first_o,
  output logic                  w_done_o,
  output logic [LdIdxWidth-1:0] w_done_idx_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CntWidth-1:0]   count_o,
  output logic                  aw_drop_o,
  output logic                  err_orphan_o,
  output logic                  err_len_o
);

  localparam int unsigned PtrWidth  = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
  localparam int unsigned BeatWidth = LenWidth + 1;

  typedef struct packed {
    logic [LdIdxWidth-1:0] idx;
    logic [LenWidth-1:0]   len;
  } entry_t;

  entry_t mem_q [MaxWrTxns];

  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  count_q, count_d;
  logic [BeatWidth-1:0] beat_cnt_q, beat_cnt_d;

  logic                 q_empty, q_full;
  logic                 whs, head_valid, hs, pop, mem_pop, push_acc;
  entry_t               aw_entry, head;
  logic [BeatWidth-1:0] head_len_ext;

  // Modulo-MaxWrTxns pointer increment; depth need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxWrTxns - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign q_empty  = (count_q == '0);
  assign q_full   = (count_q == CntWidth'(MaxWrTxns));
  assign whs      = w_valid_i & w_ready_i;
  assign aw_entry = '{idx: aw_idx_i, len: aw_len_i};

  // Empty queue with a push in flight: the new AW owns W this cycle.
  assign head         = q_empty ? aw_entry : mem_q[rd_ptr_q];
  assign head_valid   = ~q_empty | aw_push_i;
  assign head_len_ext = {1'b0, head.len};

  // Beat accepted for the owner; clear suppresses every pulse and update.
  assign hs      = whs & head_valid & ~clear_i;
  assign pop     = hs & w_last_i;
  assign mem_pop = pop & ~q_empty;

  // A bypassed entry that retires in its own cycle never touches memory.
  assign push_acc = aw_push_i & ~clear_i & ~(q_full & ~pop) & ~(q_empty & pop);

  assign active_valid_o = head_valid;
  assign active_idx_o   = head_valid ? head.idx : '0;
  assign beat_cnt_o     = beat_cnt_q;
  assign w_first_o      = hs & (beat_cnt_q == '0);
  assign w_done_o       = pop;
  assign w_done_idx_o   = pop ? head.idx : '0;
  assign err_len_o      = hs & (w_last_i ? (beat_cnt_q != head_len_ext)
                                         : (beat_cnt_q >= head_len_ext));
  assign err_orphan_o   = whs & ~head_valid & ~clear_i;
  assign aw_drop_o      = aw_push_i & ~clear_i & q_full & ~pop;
  assign full_o         = q_full;
  assign empty_o        = q_empty;
  assign count_o        = count_q;

  // Next-state for pointers, occupancy and beat counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    beat_cnt_d = beat_cnt_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      beat_cnt_d = '0;
    end else begin
      if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (mem_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_acc, mem_pop})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
      if (hs) begin
        if (w_last_i)          beat_cnt_d = '0;
        else if (~&beat_cnt_q) beat_cnt_d = beat_cnt_q + BeatWidth'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Entry storage; contents are don't-care while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= aw_entry;
  end

endmodule
